// File: rtl/pipeline_hazard_ctrl.sv
// Hazard and sequencing controller for a 5-stage MIPS32 pipeline: operand forwarding,
// load-use / branch / HI-LO stalls and the multi-cycle mult/div latency counter.
module pipeline_hazard_ctrl #(
  parameter int MUL_LAT = 4,
  parameter int DIV_LAT = 32,
  parameter int CNT_W   = 6
) (
  input  logic       clk,
  input  logic       rstN,
  input  logic [4:0] rsD,
  input  logic [4:0] rtD,
  input  logic [4:0] rsE,
  input  logic [4:0] rtE,
  input  logic [4:0] writeRegE,
  input  logic [4:0] writeRegM,
  input  logic [4:0] writeRegW,
  input  logic       regWriteE,
  input  logic       regWriteM,
  input  logic       regWriteW,
  input  logic       memToRegE,
  input  logic       memToRegM,
  input  logic       branchD,
  input  logic       mdOpD,
  input  logic       mdStartE,
  input  logic       mdIsDivE,
  output logic [1:0] forwardAE,
  output logic [1:0] forwardBE,
  output logic       forwardAD,
  output logic       forwardBD,
  output logic       stallF,
  output logic       stallD,
  output logic       flushE,
  output logic       mdBusy,
  output logic       mdDone
);

  localparam logic [CNT_W-1:0] MUL_CNT = CNT_W'(MUL_LAT);
  localparam logic [CNT_W-1:0] DIV_CNT = CNT_W'(DIV_LAT);
  localparam logic [CNT_W-1:0] ONE     = CNT_W'(1);

  logic [CNT_W-1:0] count_q, count_d;
  logic             run_q, run_d;

  logic [1:0] fwd_ae, fwd_be;
  logic       fwd_ad, fwd_bd;
  logic       lw_stall, branch_stall, hilo_stall, any_stall;
  logic       busy, done;

  function automatic logic [1:0] fwd_sel(input logic [4:0] src,
                                         input logic [4:0] dst_m, input logic we_m,
                                         input logic [4:0] dst_w, input logic we_w);
    if (src != 5'd0 && we_m && src == dst_m)      fwd_sel = 2'd2;
    else if (src != 5'd0 && we_w && src == dst_w) fwd_sel = 2'd1;
    else                                          fwd_sel = 2'd0;
  endfunction

  function automatic logic hits(input logic [4:0] dst, input logic [4:0] a, input logic [4:0] b);
    hits = (dst != 5'd0) && (dst == a || dst == b);
  endfunction

  // A new start overwrites any count in flight; otherwise count down to zero.
  always_comb begin
    run_d   = 1'b1;
    count_d = count_q;
    if (mdStartE)                count_d = mdIsDivE ? DIV_CNT : MUL_CNT;
    else if (count_q != '0)      count_d = count_q - ONE;
  end

  always_ff @(posedge clk or negedge rstN) begin
    if (!rstN) begin
      count_q <= '0;
      run_q   <= 1'b0;
    end else begin
      count_q <= count_d;
      run_q   <= run_d;
    end
  end

  always_comb begin
    fwd_ae       = fwd_sel(rsE, writeRegM, regWriteM, writeRegW, regWriteW);
    fwd_be       = fwd_sel(rtE, writeRegM, regWriteM, writeRegW, regWriteW);
    fwd_ad       = (rsD != 5'd0) && regWriteM && (rsD == writeRegM);
    fwd_bd       = (rtD != 5'd0) && regWriteM && (rtD == writeRegM);
    busy         = (count_q != '0);
    done         = (count_q == ONE);
    lw_stall     = memToRegE && hits(rtE, rsD, rtD);
    branch_stall = branchD && ((regWriteE && hits(writeRegE, rsD, rtD)) ||
                               (memToRegM && hits(writeRegM, rsD, rtD)));
    hilo_stall   = mdOpD && (busy || mdStartE);
    any_stall    = lw_stall || branch_stall || hilo_stall;
  end

  // run_q keeps every output quiet from reset assertion until the first edge after release.
  always_comb begin
    forwardAE = run_q ? fwd_ae : 2'd0;
    forwardBE = run_q ? fwd_be : 2'd0;
    forwardAD = run_q && fwd_ad;
    forwardBD = run_q && fwd_bd;
    stallF    = run_q && any_stall;
    stallD    = run_q && any_stall;
    flushE    = run_q && any_stall;
    mdBusy    = run_q && busy;
    mdDone    = run_q && done;
  end

endmodule

// File: tb/tb_pipeline_hazard_ctrl.sv
// Directed and randomized checks of pipeline_hazard_ctrl against a cycle-indexed
// reference model of forwarding, stall rules and mult/div completion times.
module tb_pipeline_hazard_ctrl;
  localparam int MUL_LAT = 4;
  localparam int DIV_LAT = 32;

  logic       clk = 1'b0;
  logic       rst_n;
  logic [4:0] rs_d, rt_d, rs_e, rt_e, wr_e, wr_m, wr_w;
  logic       rw_e, rw_m, rw_w, m2r_e, m2r_m, br_d, md_op_d, md_start_e, md_is_div_e;
  logic [1:0] forward_ae, forward_be;
  logic       forward_ad, forward_bd, stall_f, stall_d, flush_e, md_busy, md_done;

  int   tests = 0;
  int   fails = 0;
  int   cyc = 0;
  bit   have_start = 0;
  int   last_start = 0;
  int   last_lat = 0;
  bit   out_en = 0;
  logic [10:0] exp_q[$];

  always #5 clk = ~clk;

  pipeline_hazard_ctrl #(.MUL_LAT(MUL_LAT), .DIV_LAT(DIV_LAT), .CNT_W(6)) dut (
    .clk(clk), .rstN(rst_n),
    .rsD(rs_d), .rtD(rt_d), .rsE(rs_e), .rtE(rt_e),
    .writeRegE(wr_e), .writeRegM(wr_m), .writeRegW(wr_w),
    .regWriteE(rw_e), .regWriteM(rw_m), .regWriteW(rw_w),
    .memToRegE(m2r_e), .memToRegM(m2r_m), .branchD(br_d),
    .mdOpD(md_op_d), .mdStartE(md_start_e), .mdIsDivE(md_is_div_e),
    .forwardAE(forward_ae), .forwardBE(forward_be),
    .forwardAD(forward_ad), .forwardBD(forward_bd),
    .stallF(stall_f), .stallD(stall_d), .flushE(flush_e),
    .mdBusy(md_busy), .mdDone(md_done)
  );

  // Reference model: an operation started in cycle s is busy in (s, s+LAT] and done at s+LAT.
  function automatic bit model_busy();
    return have_start && cyc > last_start && cyc <= last_start + last_lat;
  endfunction

  function automatic logic [1:0] ref_fwd(input logic [4:0] src);
    if (src == 0) return 2'd0;
    if (rw_m && src == wr_m) return 2'd2;
    if (rw_w && src == wr_w) return 2'd1;
    return 2'd0;
  endfunction

  function automatic logic [10:0] ref_outs();
    bit busy, done, lw, br, hilo, st, fad, fbd;
    if (!out_en) return '0;
    busy = model_busy();
    done = have_start && cyc == last_start + last_lat;
    lw   = m2r_e && rt_e != 0 && (rt_e == rs_d || rt_e == rt_d);
    br   = br_d && ((rw_e && wr_e != 0 && (wr_e == rs_d || wr_e == rt_d)) ||
                    (m2r_m && wr_m != 0 && (wr_m == rs_d || wr_m == rt_d)));
    hilo = md_op_d && (busy || md_start_e);
    st   = lw || br || hilo;
    fad  = rs_d != 0 && rw_m && rs_d == wr_m;
    fbd  = rt_d != 0 && rw_m && rt_d == wr_m;
    return {ref_fwd(rs_e), ref_fwd(rt_e), fad, fbd, st, st, st, busy, done};
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %0h expected %0h (cycle %0d)", tag, obs, exp, cyc);
    end
  endtask

  task automatic check_all(input string tag);
    logic [10:0] obs, e;
    exp_q.push_back(ref_outs());
    obs = {forward_ae, forward_be, forward_ad, forward_bd, stall_f, stall_d, flush_e, md_busy, md_done};
    e = exp_q.pop_front();
    chk(tag, 32'(obs), 32'(e));
  endtask

  task automatic sample(input string tag);
    @(negedge clk);
    check_all(tag);
  endtask

  task automatic adv();
    if (rst_n && md_start_e) begin
      have_start = 1;
      last_start = cyc;
      last_lat   = md_is_div_e ? DIV_LAT : MUL_LAT;
    end
    @(posedge clk);
    cyc++;
    if (rst_n) out_en = 1;
    #1;
  endtask

  task automatic clear_inputs();
    {rs_d, rt_d, rs_e, rt_e, wr_e, wr_m, wr_w} = '0;
    {rw_e, rw_m, rw_w, m2r_e, m2r_m, br_d, md_op_d, md_start_e, md_is_div_e} = '0;
  endtask

  initial begin
    clear_inputs();
    rst_n = 1'b0;

    // Reset with hazard-producing inputs: everything must stay 0.
    rs_e = 5; wr_m = 5; rw_m = 1; m2r_e = 1; rt_e = 2; rs_d = 2; md_op_d = 1; md_start_e = 1;
    for (int i = 0; i < 2; i++) begin
      sample("reset");
      chk("reset_fwd_ae", 32'(forward_ae), 0);
      chk("reset_stall", 32'(stall_f), 0);
      adv();
    end
    rst_n = 1'b1;
    md_start_e = 0;
    sample("release_pre_edge");
    chk("release_fwd_ae", 32'(forward_ae), 0);
    adv();

    // Load-use hazard and its register-0 exclusion.
    clear_inputs(); m2r_e = 1; rt_e = 2; rs_d = 2;
    sample("lw_stall");
    chk("lw_stall_f", 32'(stall_f), 1);
    chk("lw_flush_e", 32'(flush_e), 1);
    adv();
    rt_e = 0; rs_d = 0;
    sample("lw_r0");
    chk("lw_r0_stall", 32'(stall_f), 0);
    adv();

    // Forwarding priority.
    clear_inputs(); rs_e = 5; wr_m = 5; rw_m = 1; wr_w = 5; rw_w = 1;
    sample("fwd_m");
    chk("fwd_m_prio", 32'(forward_ae), 2);
    adv();
    rw_m = 0;
    sample("fwd_w");
    chk("fwd_w", 32'(forward_ae), 1);
    adv();
    clear_inputs(); rt_e = 0; wr_m = 0; rw_m = 1;
    sample("fwd_r0");
    chk("fwd_be_r0", 32'(forward_be), 0);
    adv();

    // Branch depending on an ALU producer in E, then in M.
    clear_inputs(); br_d = 1; rs_d = 7; rw_e = 1; wr_e = 7;
    sample("br_e");
    chk("br_stall", 32'(stall_d), 1);
    adv();
    rw_e = 0; wr_e = 0; wr_m = 7; rw_m = 1;
    sample("br_m");
    chk("br_m_stall", 32'(stall_d), 0);
    chk("br_fwd_ad", 32'(forward_ad), 1);
    adv();

    // Multiply with a HI/LO consumer waiting in D.
    clear_inputs(); md_start_e = 1; md_op_d = 1;
    sample("mul_c0");
    chk("mul_c0_stall", 32'(stall_f), 1);
    chk("mul_c0_busy", 32'(md_busy), 0);
    adv();
    md_start_e = 0;
    for (int i = 1; i <= MUL_LAT; i++) begin
      sample("mul_run");
      chk("mul_busy", 32'(md_busy), 1);
      chk("mul_done", 32'(md_done), (i == MUL_LAT) ? 1 : 0);
      chk("mul_stall", 32'(stall_f), 1);
      adv();
    end
    sample("mul_after");
    chk("mul_after_busy", 32'(md_busy), 0);
    chk("mul_after_stall", 32'(stall_f), 0);
    adv();

    // Divide aborted by an asynchronous reset at cycle 10.
    clear_inputs(); md_start_e = 1; md_is_div_e = 1;
    sample("div_start");
    adv();
    md_start_e = 0;
    for (int i = 1; i < 10; i++) begin sample("div_run"); adv(); end
    #1 rst_n = 1'b0; have_start = 0; out_en = 0;
    #1;
    chk("abort_busy", 32'(md_busy), 0);
    chk("abort_done", 32'(md_done), 0);
    md_op_d = 1;
    for (int i = 0; i < 2; i++) begin sample("abort_reset"); adv(); end
    rst_n = 1'b1;
    sample("abort_release");
    adv();
    sample("abort_md_op");
    chk("abort_md_op_stall", 32'(stall_f), 0);
    chk("abort_md_op_busy", 32'(md_busy), 0);
    adv();
    md_op_d = 0;
    for (int i = 0; i < DIV_LAT + 2; i++) begin sample("abort_quiet"); adv(); end

    // Start honoured while a load-use flush is active.
    clear_inputs(); m2r_e = 1; rt_e = 3; rs_d = 3; md_start_e = 1; md_is_div_e = 1;
    sample("start_flush");
    chk("start_flush_e", 32'(flush_e), 1);
    adv();
    clear_inputs();
    sample("start_flush_busy");
    chk("start_flush_busy", 32'(md_busy), 1);
    adv();
    for (int i = 0; i < DIV_LAT + 1; i++) begin sample("start_flush_run"); adv(); end

    // Randomized traffic over a small register range so matches are frequent.
    for (int n = 0; n < 400; n++) begin
      rs_d = 5'($urandom_range(0, 3)); rt_d = 5'($urandom_range(0, 3));
      rs_e = 5'($urandom_range(0, 3)); rt_e = 5'($urandom_range(0, 3));
      wr_e = 5'($urandom_range(0, 3)); wr_m = 5'($urandom_range(0, 3));
      wr_w = 5'($urandom_range(0, 3));
      rw_e = 1'($urandom); rw_m = 1'($urandom); rw_w = 1'($urandom);
      m2r_e = ($urandom_range(0, 3) == 0); m2r_m = ($urandom_range(0, 3) == 0);
      br_d = 1'($urandom); md_op_d = 1'($urandom);
      md_is_div_e = ($urandom_range(0, 3) == 0);
      md_start_e = model_busy() ? ($urandom_range(0, 49) == 0) : ($urandom_range(0, 5) == 0);
      sample("random");
      adv();
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
